// File: rtl/uart_pkg.sv
// uart_pkg: shared parity/state types, baud table and divider helper for the UART transmitter
package uart_pkg;
    typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK} parity_t;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
    localparam int DIV_W = 24;
    localparam int BAUD_TABLE [0:7] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};
    function automatic logic [DIV_W-1:0] baud_div(input int clk_freq, input logic [2:0] sel);
        int baud;
        baud = BAUD_TABLE[sel];
        return DIV_W'((clk_freq + 8 * baud) / (16 * baud));
    endfunction
endpackage

// File: rtl/uart_tx_baud_gen.sv
// uart_tx_baud_gen: prescaler giving a sample tick every div clocks and a bit tick every 16 sample ticks
module uart_tx_baud_gen
    import uart_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             bit_tick
);
    logic [DIV_W-1:0] cnt;
    logic [3:0]       tick_cnt;
    logic             sample_tick;
    assign sample_tick = cnt == div - DIV_W'(1);
    assign bit_tick    = sample_tick & (tick_cnt == 4'd15);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            tick_cnt <= '0;
        end else if (restart) begin
            cnt      <= '0;
            tick_cnt <= '0;
        end else if (sample_tick) begin
            cnt      <= '0;
            tick_cnt <= tick_cnt + 4'd1;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter (data width, parity, stop bits, baud select).
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry TX FIFO; otherwise a single holding register.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] Tx_DATA,
    input  logic                  Tx_WR,
    input  logic                  Tx_EN,
    input  logic [2:0]            baud_select,
    input  logic [1:0]            parity_mode,
    input  logic                  stop_bits,
    output logic                  TxD,
    output logic                  Tx_BUSY,
    output logic                  Tx_FULL,
    output logic                  Tx_OVF
);
    tx_state_t             state, state_n;
    parity_t               par_q;
    logic [DATA_WIDTH-1:0] shreg, head;
    logic [DIV_W-1:0]      div;
    logic [3:0]            bit_cnt;
    logic [2:0]            baud_q;
    logic                  stop_cnt, stop_q, par_bit, pop, full, empty, bit_tick, wr_req, avail;
    assign wr_req  = Tx_WR & Tx_EN & !full;
    assign avail   = !empty & Tx_EN;
    assign div     = baud_div(CLK_FREQ, baud_q);
    assign Tx_FULL = full;
    assign Tx_BUSY = (state != IDLE) | !empty;
    assign TxD     = state == START ? 1'b0 : state == DATA ? shreg[0] : state == PARITY ? par_bit : 1'b1;
`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wp, rp;
    logic [CW-1:0]         count;
    assign full  = count == CW'(FIFO_DEPTH);
    assign empty = count == '0;
    assign head  = mem[rp];
    always_ff @(posedge clock) begin
        if (wr_req) mem[wp] <= Tx_DATA;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wr_req ? wp + AW'(1) : wp;
            rp    <= pop ? rp + AW'(1) : rp;
            count <= count + CW'(wr_req) - CW'(pop);
        end
    end
`else
    logic [DATA_WIDTH-1:0] hold;
    logic                  valid;
    assign full  = valid;
    assign empty = !valid;
    assign head  = hold;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold  <= '0;
            valid <= 1'b0;
        end else if (wr_req) begin
            hold  <= Tx_DATA;
            valid <= 1'b1;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end
`endif
    uart_tx_baud_gen u_baud (
        .clock    (clock),
        .reset    (reset),
        .restart  (pop),
        .div      (div),
        .bit_tick (bit_tick)
    );
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end
    // A pop always restarts the baud generator, so every frame starts on a fresh bit boundary
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                pop     = avail;
                state_n = avail ? START : IDLE;
            end
            START:   state_n = bit_tick ? DATA : START;
            DATA:    if (bit_tick && bit_cnt == 4'(DATA_WIDTH - 1)) state_n = par_q == PAR_NONE ? STOP : PARITY;
            PARITY:  state_n = bit_tick ? STOP : PARITY;
            STOP: if (bit_tick && stop_cnt == stop_q) begin
                pop     = avail;
                state_n = avail ? START : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            stop_q   <= 1'b0;
            par_q    <= PAR_NONE;
            par_bit  <= 1'b0;
            baud_q   <= '0;
            Tx_OVF   <= 1'b0;
        end else begin
            Tx_OVF <= Tx_WR & Tx_EN & full;
            if (pop) begin
                shreg    <= head;
                bit_cnt  <= '0;
                stop_cnt <= 1'b0;
                stop_q   <= stop_bits;
                par_q    <= parity_t'(parity_mode);
                par_bit  <= (parity_mode == PAR_MARK) | ((parity_mode == PAR_ODD) ^ (^head));
                baud_q   <= baud_select;
            end else if (bit_tick) begin
                shreg    <= state == DATA ? shreg >> 1 : shreg;
                bit_cnt  <= state == DATA ? bit_cnt + 4'd1 : bit_cnt;
                stop_cnt <= state == STOP ? 1'b1 : stop_cnt;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed self-checking bench for uart_tx_param at 50 MHz (432-clock bits at 115200).
module tb_uart_tx_param;
    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] Tx_DATA;
    logic       Tx_WR, Tx_EN, stop_bits;
    logic [2:0] baud_select;
    logic [1:0] parity_mode;
    logic       TxD, Tx_BUSY, Tx_FULL, Tx_OVF;
    int         n_chk = 0;
    int         n_fail = 0;
    int         lows;
    uart_tx_param #(.CLK_FREQ(50_000_000), .DATA_WIDTH(8), .FIFO_DEPTH(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .Tx_DATA     (Tx_DATA),
        .Tx_WR       (Tx_WR),
        .Tx_EN       (Tx_EN),
        .baud_select (baud_select),
        .parity_mode (parity_mode),
        .stop_bits   (stop_bits),
        .TxD         (TxD),
        .Tx_BUSY     (Tx_BUSY),
        .Tx_FULL     (Tx_FULL),
        .Tx_OVF      (Tx_OVF)
    );
    always #5 clock = ~clock;
    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic send(input logic [7:0] d);
        Tx_DATA = d;
        Tx_WR   = 1'b1;
        @(negedge clock);
        Tx_WR = 1'b0;
    endtask
    // Called at offset skip (cycles) into a frame; checks first and last cycle of every bit, returns at offset n*len
    task automatic check_frame(input string tag, input logic [15:0] f, input int n, input int len, input int skip);
        int pos;
        pos = skip;
        for (int k = 0; k < n; k++) begin
            if (k * len >= pos) begin
                repeat (k * len - pos) @(negedge clock);
                pos = k * len;
                check($sformatf("%s bit%0d first", tag, k), 32'(TxD), 32'(f[k]));
            end
            repeat ((k + 1) * len - 1 - pos) @(negedge clock);
            pos = (k + 1) * len - 1;
            check($sformatf("%s bit%0d last", tag, k), 32'(TxD), 32'(f[k]));
        end
        @(negedge clock);
    endtask
    task automatic run_frame(input string tag, input logic [7:0] d, input logic [15:0] f, input int n);
        send(d);
        @(negedge clock);
        check_frame(tag, f, n, 432, 0);
        check({tag, " busy after"}, 32'(Tx_BUSY), 0);
    endtask
    initial begin
        reset = 1'b0; Tx_WR = 1'b0; Tx_EN = 1'b1; Tx_DATA = '0;
        baud_select = 3'd7; parity_mode = 2'b00; stop_bits = 1'b0;
        repeat (3) @(negedge clock);
        check("rst TxD", 32'(TxD), 1);
        check("rst busy", 32'(Tx_BUSY), 0);
        check("rst full", 32'(Tx_FULL), 0);
        check("rst ovf", 32'(Tx_OVF), 0);
        reset = 1'b1;
        @(negedge clock);
        // Test 1: 8'hA5, no parity, one stop bit
        send(8'hA5);
        check("t1 idle before start", 32'(TxD), 1);
        check("t1 busy", 32'(Tx_BUSY), 1);
        @(negedge clock);
        check("t1 start N+1", 32'(TxD), 0);
        check_frame("t1", 16'({1'b1, 8'hA5, 1'b0}), 10, 432, 0);
        check("t1 busy low", 32'(Tx_BUSY), 0);
        check("t1 TxD idle", 32'(TxD), 1);
        // Test 2: parity modes and stop bits
        parity_mode = 2'b01;
        run_frame("t2 even", 8'h07, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11);
        parity_mode = 2'b10; stop_bits = 1'b1;
        run_frame("t2 odd 2stop", 8'h07, 16'({2'b11, 1'b0, 8'h07, 1'b0}), 12);
        parity_mode = 2'b11; stop_bits = 1'b0;
        run_frame("t2 mark", 8'h00, 16'({1'b1, 1'b1, 8'h00, 1'b0}), 11);
        parity_mode = 2'b00;
        // Test 3: overflow and back-to-back frames
`ifdef UART_TX_FIFO_EN
        for (int i = 0; i < 18; i++) begin
            Tx_DATA = 8'(i);
            Tx_WR   = 1'b1;
            @(negedge clock);
            check($sformatf("t3 ovf w%0d", i), 32'(Tx_OVF), 32'(i == 17));
            check($sformatf("t3 full w%0d", i), 32'(Tx_FULL), 32'(i >= 16));
        end
        Tx_WR = 1'b0;
        @(negedge clock);
        check("t3 ovf single", 32'(Tx_OVF), 0);
        check_frame("t3 w0", 16'({1'b1, 8'h00, 1'b0}), 10, 432, 17);
        check_frame("t3 w1", 16'({1'b1, 8'h01, 1'b0}), 3, 432, 0);
        check("t3 full after pop", 32'(Tx_FULL), 0);
        check("t3 busy", 32'(Tx_BUSY), 1);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
`else
        Tx_DATA = 8'h3C; Tx_WR = 1'b1;
        @(negedge clock);
        check("t3 full", 32'(Tx_FULL), 1);
        check("t3 ovf none", 32'(Tx_OVF), 0);
        Tx_DATA = 8'hFF;
        @(negedge clock);
        check("t3 ovf pulse", 32'(Tx_OVF), 1);
        check("t3 full popped", 32'(Tx_FULL), 0);
        check("t3 start", 32'(TxD), 0);
        Tx_DATA = 8'h81;
        @(negedge clock);
        Tx_WR = 1'b0;
        check("t3 ovf once", 32'(Tx_OVF), 0);
        check("t3 full again", 32'(Tx_FULL), 1);
        check_frame("t3 w0", 16'({1'b1, 8'h3C, 1'b0}), 10, 432, 1);
        check_frame("t3 w1 gapless", 16'({1'b1, 8'h81, 1'b0}), 10, 432, 0);
        check("t3 busy low", 32'(Tx_BUSY), 0);
`endif
        // Test 4: Tx_EN dropped mid-DATA with a word buffered
        send(8'h5A);
        @(negedge clock);
        check("t4 start", 32'(TxD), 0);
        send(8'hC3);
        repeat (1305) @(negedge clock);
        Tx_EN = 1'b0;
        send(8'hFF);
        check("t4 wr disabled ovf", 32'(Tx_OVF), 0);
        repeat (3672 - 1307) @(negedge clock);
        check("t4 frame continues bit7", 32'(TxD), 0);
        repeat (4320 - 3672) @(negedge clock);
        check("t4 busy held", 32'(Tx_BUSY), 1);
        lows = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clock);
            if (!TxD) lows++;
        end
        check("t4 line idle", 32'(lows), 0);
        check("t4 busy still", 32'(Tx_BUSY), 1);
        Tx_EN = 1'b1;
        @(negedge clock);
        check_frame("t4 resume", 16'({1'b1, 8'hC3, 1'b0}), 10, 432, 0);
        check("t4 busy low", 32'(Tx_BUSY), 0);
        // Test 5: baud_select change mid-frame applies to the next frame only
        send(8'h96);
        @(negedge clock);
        check("t5 start", 32'(TxD), 0);
        baud_select = 3'd3;
        send(8'h01);
        check_frame("t5 old baud", 16'({1'b1, 8'h96, 1'b0}), 10, 432, 1);
        check_frame("t5 new baud", 16'({8'h01, 1'b0}), 2, 5216, 0);
        // Test 6: reset mid-frame
        check("t6 mid-frame low", 32'(TxD), 0);
        send(8'hAA);
        check("t6 busy", 32'(Tx_BUSY), 1);
        reset = 1'b0;
        #1;
        check("t6 async TxD", 32'(TxD), 1);
        check("t6 busy", 32'(Tx_BUSY), 0);
        check("t6 flushed", 32'(Tx_FULL), 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        baud_select = 3'd7;
        lows = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            if (!TxD) lows++;
        end
        check("t6 no resume", 32'(lows), 0);
        check("t6 busy idle", 32'(Tx_BUSY), 0);
        run_frame("t6 fresh", 8'h4D, 16'({1'b1, 8'h4D, 1'b0}), 10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
